// File: rtl/int_sink_pkg.sv
// Shared types for the int_sink stream checker/consumer and its buffer.
package int_sink_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DRAIN,
    HALT
  } state_e;

endpackage

// File: rtl/int_sink_fifo.sv
// First-word fall-through buffer; the head shows the last popped word while empty.
module int_sink_fifo
  import int_sink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  word_t data_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output logic  lastEntry_o,
  output word_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

  word_t         mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  word_t         last_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wrPtr_q] <= data_i;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + 1'b1;
        last_q  <= mem_q[rdPtr_q];
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == FULL_CNT);
  assign lastEntry_o = (count_q == ONE_CNT);
  assign head_o      = empty_o ? last_q : mem_q[rdPtr_q];

endmodule

// File: rtl/int_sink.sv
// Stream sink: accepts NUM_WORDS words, scores each against EXPECTED, buffers
// them for a reader, then drains and halts until reset.
module int_sink
  import int_sink_pkg::*;
#(
  parameter word_t EXPECTED  = 32'd42,
  parameter int    NUM_WORDS = 1,
  parameter int    DEPTH     = 4,
  parameter int    CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  word_t            in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output word_t            out_data,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err,
  output logic             done
);

  localparam int WC_W = $clog2(NUM_WORDS + 1);
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(NUM_WORDS - 1);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wordCnt_q, wordCnt_d;
  logic [CNT_W-1:0] matchCnt_q, matchCnt_d;
  logic [CNT_W-1:0] mismatchCnt_q, mismatchCnt_d;
  logic             err_q, err_d;
  logic             full, empty, lastEntry, accept, pop;

  assign in_ready  = (state_q == RECV) && !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  int_sink_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (accept),
    .data_i     (in_data),
    .pop_i      (pop),
    .full_o     (full),
    .empty_o    (empty),
    .lastEntry_o(lastEntry),
    .head_o     (out_data)
  );

  // DRAIN ends on the edge that leaves the buffer empty, including the final pop.
  always_comb begin
    state_d       = state_q;
    wordCnt_d     = wordCnt_q;
    matchCnt_d    = matchCnt_q;
    mismatchCnt_d = mismatchCnt_q;
    err_d         = err_q;
    case (state_q)
      IDLE:    state_d = RECV;
      RECV:    if (accept && (wordCnt_q == LAST_IDX)) state_d = DRAIN;
      DRAIN:   if (empty || (pop && lastEntry)) state_d = HALT;
      default: state_d = state_q;
    endcase
    if (accept) begin
      wordCnt_d = wordCnt_q + 1'b1;
      if (in_data == EXPECTED) begin
        if (!(&matchCnt_q)) matchCnt_d = matchCnt_q + 1'b1;
      end else begin
        if (!(&mismatchCnt_q)) mismatchCnt_d = mismatchCnt_q + 1'b1;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wordCnt_q     <= '0;
      matchCnt_q    <= '0;
      mismatchCnt_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wordCnt_q     <= wordCnt_d;
      matchCnt_q    <= matchCnt_d;
      mismatchCnt_q <= mismatchCnt_d;
      err_q         <= err_d;
    end
  end

  assign match_cnt    = matchCnt_q;
  assign mismatch_cnt = mismatchCnt_q;
  assign err          = err_q;
  assign done         = (state_q == HALT);

endmodule

// File: tb/tb_int_sink.sv
// Bench for int_sink: four instances with different word counts and counter
// widths, each scored every cycle against a queue-based model of the sink.
module tb_int_sink;

  localparam int NW [4] = '{1, 6, 8, 5};
  localparam int CW [4] = '{8, 8, 8, 2};

  logic             clk = 1'b0;
  logic [3:0]       rstN = 4'b0000;
  logic [3:0]       inValid = '0;
  logic [3:0]       outReady = '0;
  logic [3:0][31:0] inData = '0;
  logic [3:0]       inReady, outValid, errO, doneO;
  logic [3:0][31:0] outData;
  logic [3:0][7:0]  matchCnt, mismatchCnt;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] stimWords [16];

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gInst
    logic [CW[g]-1:0] mcW, mmcW;

    int_sink #(.EXPECTED(32'd42), .NUM_WORDS(NW[g]), .DEPTH(4), .CNT_W(CW[g])) dut (
      .clk         (clk),
      .rst_n       (rstN[g]),
      .in_valid    (inValid[g]),
      .in_ready    (inReady[g]),
      .in_data     (inData[g]),
      .out_valid   (outValid[g]),
      .out_ready   (outReady[g]),
      .out_data    (outData[g]),
      .match_cnt   (mcW),
      .mismatch_cnt(mmcW),
      .err         (errO[g]),
      .done        (doneO[g])
    );

    assign matchCnt[g]    = 8'(mcW);
    assign mismatchCnt[g] = 8'(mmcW);

    // Model: the buffer is a queue; the sink is "started" one edge after reset,
    // takes words while it has taken fewer than NW, and halts once finished and empty.
    logic [31:0] q[$];
    int acc = 0, mc = 0, mmc = 0;
    bit er = 0, started = 0, halted = 0;

    always @(posedge clk or negedge rstN[g]) begin
      bit rdy, finished;
      if (!rstN[g]) begin
        q.delete();
        acc = 0; mc = 0; mmc = 0;
        er = 0; started = 0; halted = 0;
      end else if (!started) begin
        started = 1;
      end else begin
        finished = (acc == NW[g]);
        rdy = !halted && (acc < NW[g]) && (q.size() < 4);
        if (q.size() > 0 && outReady[g]) void'(q.pop_front());
        if (rdy && inValid[g]) begin
          q.push_back(inData[g]);
          acc++;
          if (inData[g] == 32'd42) begin
            if (mc < (1 << CW[g]) - 1) mc++;
          end else begin
            if (mmc < (1 << CW[g]) - 1) mmc++;
            er = 1;
          end
        end
        if (finished && q.size() == 0) halted = 1;
      end
    end

    always @(negedge clk) begin
      checkOutput($sformatf("g%0d in_ready", g), 32'(inReady[g]),
                  32'(started && !halted && (acc < NW[g]) && (q.size() < 4)));
      checkOutput($sformatf("g%0d out_valid", g), 32'(outValid[g]), 32'(q.size() > 0));
      if (q.size() > 0)
        checkOutput($sformatf("g%0d out_data", g), outData[g], q[0]);
      checkOutput($sformatf("g%0d match_cnt", g), 32'(matchCnt[g]), 32'(mc));
      checkOutput($sformatf("g%0d mismatch_cnt", g), 32'(mismatchCnt[g]), 32'(mmc));
      checkOutput($sformatf("g%0d err", g), 32'(errO[g]), 32'(er));
      checkOutput($sformatf("g%0d done", g), 32'(doneO[g]), 32'(halted));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [31:0] d, input logic r);
    inValid[idx]  = v;
    inData[idx]   = d;
    outReady[idx] = r;
    tick();
  endtask

  task automatic streamWords(input int idx, input int first, input int n,
                             input int maxCycles, output int got);
    bit rdy;
    got = 0;
    for (int c = 0; c < maxCycles && got < n; c++) begin
      inValid[idx] = 1'b1;
      inData[idx]  = stimWords[first + got];
      rdy = inReady[idx];
      tick();
      if (rdy) got++;
    end
    inValid[idx] = 1'b0;
  endtask

  task automatic waitDone(input int idx, input int bound);
    for (int c = 0; c < bound && !doneO[idx]; c++) tick();
    checkOutput($sformatf("g%0d done within %0d cycles", idx, bound), 32'(doneO[idx]), 32'd1);
  endtask

  task automatic pulseReset(input int idx);
    rstN[idx] = 1'b0;
    tick();
    rstN[idx] = 1'b1;
    tick();
  endtask

  initial begin
    int got;

    // Reset state, still inside reset.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst in_ready", 32'(inReady[0]), 32'd0);
    checkOutput("rst out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("rst out_data", outData[0], 32'd0);
    checkOutput("rst match_cnt", 32'(matchCnt[0]), 32'd0);
    checkOutput("rst err", 32'(errO[0]), 32'd0);
    checkOutput("rst done", 32'(doneO[0]), 32'd0);
    rstN = 4'b1111;
    tick();
    checkOutput("t1 in_ready after IDLE", 32'(inReady[0]), 32'd1);

    // One matching word with the reader always ready.
    applyStimulus(0, 1'b1, 32'd42, 1'b1);
    checkOutput("t1 match_cnt", 32'(matchCnt[0]), 32'd1);
    checkOutput("t1 out_data", outData[0], 32'd42);
    checkOutput("t1 out_valid", 32'(outValid[0]), 32'd1);
    checkOutput("t1 in_ready drain", 32'(inReady[0]), 32'd0);
    applyStimulus(0, 1'b0, 32'd0, 1'b1);
    checkOutput("t1 done", 32'(doneO[0]), 32'd1);
    checkOutput("t1 out_data held", outData[0], 32'd42);
    repeat (3) tick();
    checkOutput("t1 done stays", 32'(doneO[0]), 32'd1);
    checkOutput("t1 in_ready halt", 32'(inReady[0]), 32'd0);

    // One mismatching word; err must survive into HALT.
    pulseReset(0);
    applyStimulus(0, 1'b1, 32'd41, 1'b1);
    checkOutput("t2 mismatch_cnt", 32'(mismatchCnt[0]), 32'd1);
    checkOutput("t2 err", 32'(errO[0]), 32'd1);
    applyStimulus(0, 1'b0, 32'd0, 1'b1);
    repeat (2) tick();
    checkOutput("t2 done", 32'(doneO[0]), 32'd1);
    checkOutput("t2 err sticky", 32'(errO[0]), 32'd1);

    // Fill to full with the reader stalled, then release it.
    stimWords[0] = 32'd100; stimWords[1] = 32'd101; stimWords[2] = 32'd42;
    stimWords[3] = 32'd103; stimWords[4] = 32'd104; stimWords[5] = 32'd105;
    outReady[1] = 1'b0;
    streamWords(1, 0, 6, 6, got);
    checkOutput("t3 accepted while stalled", 32'(got), 32'd4);
    checkOutput("t3 in_ready full", 32'(inReady[1]), 32'd0);
    checkOutput("t3 head", outData[1], 32'd100);
    outReady[1] = 1'b1;
    streamWords(1, 4, 2, 20, got);
    checkOutput("t3 remaining accepted", 32'(got), 32'd2);
    waitDone(1, 20);
    checkOutput("t3 match_cnt", 32'(matchCnt[1]), 32'd1);
    checkOutput("t3 mismatch_cnt", 32'(mismatchCnt[1]), 32'd5);

    // Steady push+pop with two words buffered, wrapping the pointers twice.
    for (int i = 0; i < 8; i++) stimWords[i] = 32'd200 + 32'(i);
    outReady[2] = 1'b0;
    streamWords(2, 0, 2, 2, got);
    checkOutput("t4 preload", 32'(got), 32'd2);
    outReady[2] = 1'b1;
    streamWords(2, 2, 6, 6, got);
    checkOutput("t4 streamed", 32'(got), 32'd6);
    checkOutput("t4 head after wrap", outData[2], 32'd206);
    checkOutput("t4 out_valid", 32'(outValid[2]), 32'd1);
    waitDone(2, 10);

    // Asynchronous reset between edges with three words buffered.
    pulseReset(1);
    outReady[1] = 1'b0;
    stimWords[0] = 32'd300; stimWords[1] = 32'd301; stimWords[2] = 32'd302;
    streamWords(1, 0, 3, 3, got);
    checkOutput("t5 buffered", 32'(got), 32'd3);
    checkOutput("t5 err before", 32'(errO[1]), 32'd1);
    #2;
    rstN[1] = 1'b0;
    #1;
    checkOutput("t5 out_valid async", 32'(outValid[1]), 32'd0);
    checkOutput("t5 mismatch async", 32'(mismatchCnt[1]), 32'd0);
    checkOutput("t5 err async", 32'(errO[1]), 32'd0);
    tick();
    rstN[1] = 1'b1;
    checkOutput("t5 in_ready idle", 32'(inReady[1]), 32'd0);
    tick();
    checkOutput("t5 in_ready recv", 32'(inReady[1]), 32'd1);

    // Two-bit match counter saturates at 3.
    for (int i = 0; i < 5; i++) stimWords[i] = 32'd42;
    outReady[3] = 1'b1;
    streamWords(3, 0, 3, 6, got);
    checkOutput("t6 match after 3", 32'(matchCnt[3]), 32'd3);
    streamWords(3, 3, 2, 6, got);
    checkOutput("t6 match saturated", 32'(matchCnt[3]), 32'd3);
    checkOutput("t6 err", 32'(errO[3]), 32'd0);
    waitDone(3, 10);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
